// File: rtl/game_pkg.sv
// Shared types for the multimode game core: counting modes, game result and FSM states.
package game_pkg;

   typedef enum logic [1:0] {
      MODE_INC1 = 2'd0,
      MODE_INC2 = 2'd1,
      MODE_DEC1 = 2'd2,
      MODE_DEC2 = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      WHO_NONE   = 2'd0,
      WHO_LOSER  = 2'd1,
      WHO_WINNER = 2'd2
   } who_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_e;

endpackage

// File: rtl/tally_counter.sv
// Saturating event tally with synchronous clear; hit flags that the next value reaches TARGET.
module tally_counter #(
   parameter int unsigned TARGET = 15,
   parameter int unsigned TW     = $clog2(TARGET + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [TW-1:0] cnt,
   output logic          hit
);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_q;
      if (clr) begin
         cnt_next = '0;
      end else if (inc && (cnt_q != TW'(TARGET))) begin
         cnt_next = cnt_q + TW'(1);
      end
   end

   assign hit = (cnt_next == TW'(TARGET));
   assign cnt = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_next;
      end
   end

endmodule

// File: rtl/multimode_game_core.sv
// Mode counter with winner/loser tallies and a game FSM (IDLE -> PLAY -> OVER -> PLAY).
module multimode_game_core
   import game_pkg::*;
#(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned WIN_TARGET = 15,
   parameter int unsigned GO_HOLD    = 1,
   parameter int unsigned TW         = $clog2(WIN_TARGET + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic [WIDTH-1:0] init_val,
   input  logic             en,
   input  logic [1:0]       control,
   output logic [WIDTH-1:0] count,
   output logic             winner,
   output logic             loser,
   output logic [TW-1:0]    win_tally,
   output logic [TW-1:0]    lose_tally,
   output logic             gameover,
   output logic [1:0]       who
);

   localparam int unsigned HW = $clog2(GO_HOLD + 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] load_q, load_d;
   logic             winner_q, winner_d;
   logic             loser_q, loser_d;
   logic             gameover_q, gameover_d;
   who_e             who_q, who_d;
   logic [HW-1:0]    hold_q, hold_d;

   logic [WIDTH-1:0] nxt;
   logic             win_inc, lose_inc, tally_clr;
   logic             win_hit, lose_hit;

   always_comb begin
      nxt = count_q;
      unique case (mode_e'(control))
         MODE_INC1: nxt = count_q + WIDTH'(1);
         MODE_INC2: nxt = count_q + WIDTH'(2);
         MODE_DEC1: nxt = count_q - WIDTH'(1);
         MODE_DEC2: nxt = count_q - WIDTH'(2);
         default:   nxt = count_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      load_d     = load_q;
      winner_d   = 1'b0;
      loser_d    = 1'b0;
      gameover_d = gameover_q;
      who_d      = who_q;
      hold_d     = hold_q;
      win_inc    = 1'b0;
      lose_inc   = 1'b0;
      tally_clr  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (init) begin
               count_d = init_val;
               load_d  = init_val;
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (init) begin
               count_d = init_val;
               load_d  = init_val;
            end else if (en) begin
               count_d  = nxt;
               winner_d = (nxt == '1);
               loser_d  = (nxt == '0);
               win_inc  = winner_d;
               lose_inc = loser_d;
               // hit reflects the tally value after this edge's increment
               if (win_inc && win_hit) begin
                  gameover_d = 1'b1;
                  who_d      = WHO_WINNER;
                  hold_d     = '0;
                  state_d    = OVER;
               end else if (lose_inc && lose_hit) begin
                  gameover_d = 1'b1;
                  who_d      = WHO_LOSER;
                  hold_d     = '0;
                  state_d    = OVER;
               end
            end
         end
         OVER: begin
            if (hold_q == HW'(GO_HOLD - 1)) begin
               count_d    = load_q;
               tally_clr  = 1'b1;
               gameover_d = 1'b0;
               who_d      = WHO_NONE;
               hold_d     = '0;
               state_d    = PLAY;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         load_q     <= '0;
         winner_q   <= 1'b0;
         loser_q    <= 1'b0;
         gameover_q <= 1'b0;
         who_q      <= WHO_NONE;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         load_q     <= load_d;
         winner_q   <= winner_d;
         loser_q    <= loser_d;
         gameover_q <= gameover_d;
         who_q      <= who_d;
         hold_q     <= hold_d;
      end
   end

   tally_counter #(
      .TARGET(WIN_TARGET),
      .TW    (TW)
   ) u_win_tally (
      .clk(clk),
      .rst(rst),
      .clr(tally_clr),
      .inc(win_inc),
      .cnt(win_tally),
      .hit(win_hit)
   );

   tally_counter #(
      .TARGET(WIN_TARGET),
      .TW    (TW)
   ) u_lose_tally (
      .clk(clk),
      .rst(rst),
      .clr(tally_clr),
      .inc(lose_inc),
      .cnt(lose_tally),
      .hit(lose_hit)
   );

   assign count    = count_q;
   assign winner   = winner_q;
   assign loser    = loser_q;
   assign gameover = gameover_q;
   assign who      = who_q;

endmodule
